pwm_deserializer: RTL

PWM_DESERIALIZER -- requirements
Module: pwm_deserializer

---
 rtl/pwm_deserializer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/pwm_deserializer.sv
// PWM decoder: measures period and high time, reports duty on a 0..1023 scale 11 cycles after each closing rising edge.
// Optional PWM_DESERIALIZER_FILTER_EN adds a 3-sample glitch filter on the synchronized input.
module pwm_deserializer #(
  parameter  int PERIOD_WIDTH_NS = 1000,
  parameter  int SYS_FREQ_MHZ    = 50,
  localparam int PERIOD          = PERIOD_WIDTH_NS * SYS_FREQ_MHZ / 1000,
  localparam int TIMEOUT         = 2 * PERIOD,
  localparam int CNT_BITS        = $clog2(TIMEOUT) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pwm_in,
  output logic [9:0]          duty_cycle,
  output logic                duty_valid,
  output logic [CNT_BITS-1:0] period_cycles,
  output logic                signal_lost,
  output logic                overrun
);

  localparam int DW = CNT_BITS + 10;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t              state, state_nxt;
  logic [CNT_BITS-1:0] per_cnt, high_cnt, per_nxt, high_nxt;
  logic                handoff, timeout;
  logic                sync1, sync2, sync3;
  logic                rise, fall, cur_level;

  logic                div_busy;
  logic [3:0]          div_step;
  logic [DW-1:0]       div_rem, div_den;
  logic [9:0]          div_q;
  logic [CNT_BITS-1:0] div_per;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

`ifdef PWM_DESERIALIZER_FILTER_EN
  logic sync4, level, accept;

  // A new level is taken only when three consecutive samples agree.
  assign accept    = (sync2 == sync3) && (sync3 == sync4) && (sync2 != level);
  assign rise      = accept & sync2;
  assign fall      = accept & ~sync2;
  assign cur_level = level;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync4 <= 1'b0;
      level <= 1'b0;
    end else begin
      sync4 <= sync3;
      if (accept) level <= sync2;
    end
  end
`else
  assign rise      = sync2 & ~sync3;
  assign fall      = ~sync2 & sync3;
  assign cur_level = sync2;
`endif

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (&v) ? v : v + CNT_BITS'(1);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      per_cnt  <= '0;
      high_cnt <= '0;
    end else begin
      state    <= state_nxt;
      per_cnt  <= per_nxt;
      high_cnt <= high_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    per_nxt   = per_cnt;
    high_nxt  = high_cnt;
    handoff   = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = HIGH;
          per_nxt   = CNT_BITS'(1);
          high_nxt  = CNT_BITS'(1);
        end
      end
      HIGH, LOW: begin
        if (per_cnt >= CNT_BITS'(TIMEOUT)) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
          per_nxt   = '0;
          high_nxt  = '0;
        end else if (state == HIGH) begin
          // The falling-edge cycle already belongs to the low phase.
          per_nxt = sat_inc(per_cnt);
          if (fall) state_nxt = LOW;
          else      high_nxt  = sat_inc(high_cnt);
        end else if (rise) begin
          handoff   = 1'b1;
          state_nxt = HIGH;
          per_nxt   = CNT_BITS'(1);
          high_nxt  = CNT_BITS'(1);
        end else begin
          per_nxt = sat_inc(per_cnt);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Restoring divider: quotient bit i is set when rem >= per << i, MSB first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_busy      <= 1'b0;
      div_step      <= '0;
      div_rem       <= '0;
      div_den       <= '0;
      div_q         <= '0;
      div_per       <= '0;
      duty_cycle    <= '0;
      duty_valid    <= 1'b0;
      period_cycles <= '0;
      signal_lost   <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      if (state == IDLE && rise) signal_lost <= 1'b0;
      if (timeout) begin
        div_busy      <= 1'b0;
        duty_cycle    <= cur_level ? 10'd1023 : 10'd0;
        period_cycles <= '0;
        duty_valid    <= 1'b1;
        signal_lost   <= 1'b1;
      end else begin
        if (div_busy) begin
          if (div_step != 4'd0) begin
            if (div_rem >= div_den) begin
              div_rem <= div_rem - div_den;
              div_q   <= {div_q[8:0], 1'b1};
            end else begin
              div_q   <= {div_q[8:0], 1'b0};
            end
            div_den  <= div_den >> 1;
            div_step <= div_step - 4'd1;
          end else begin
            duty_cycle    <= div_q;
            period_cycles <= div_per;
            duty_valid    <= 1'b1;
            div_busy      <= 1'b0;
          end
        end
        if (handoff) begin
          if (div_busy) begin
            overrun <= 1'b1;
          end else begin
            div_busy <= 1'b1;
            div_step <= 4'd10;
            div_rem  <= DW'(high_cnt) * DW'(1023);
            div_den  <= DW'(per_cnt) << 9;
            div_q    <= '0;
            div_per  <= per_cnt;
          end
        end
      end
    end
  end

endmodule
